// File: rtl/sq_cmd_scheduler.sv
// NVMe submission-queue command scheduler: moves 16-word commands from a FIFO
// to the host-write engine, one SQ slot per command, then rings the tail doorbell.
module sq_cmd_scheduler #(
    parameter int SQ_DEPTH  = 64,
    parameter int CMD_WORDS = 16
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        enable,
    input  logic [14:0] fifo_data_count,
    input  logic [31:0] fifo_data,
    output logic        fifo_pop,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [31:0] m_data,
    output logic [7:0]  m_slot,
    output logic [3:0]  m_word,
    output logic        m_last,
    input  logic        sq_head_valid,
    input  logic [7:0]  sq_head,
    output logic        db_valid,
    input  logic        db_ready,
    output logic [7:0]  db_value,
    output logic [7:0]  sq_tail,
    output logic [7:0]  sq_head_q,
    output logic        sq_full,
    output logic        underrun_err
);

    localparam int         PW        = (SQ_DEPTH > 1) ? $clog2(SQ_DEPTH) : 1;
    localparam logic [3:0] LAST_WORD = 4'(CMD_WORDS - 1);

    typedef enum logic [1:0] {IDLE, XFER, DOORBELL} state_t;

    state_t          state;
    logic [3:0]      word_cnt;
    logic [PW-1:0]   tail_q;
    logic [PW-1:0]   head_q;
    logic [PW-1:0]   tail_inc;
    logic            underrun_q;
    logic            in_xfer;
    logic            in_db;
    logic            has_data;
    logic            beat;
    logic            unused_head_hi;

    assign in_xfer  = (state == XFER);
    assign in_db    = (state == DOORBELL);
    assign has_data = (fifo_data_count != 15'd0);
    assign tail_inc = tail_q + PW'(1);

    // Beat outputs are gated by state so reset (which forces IDLE) zeroes them at once.
    assign m_valid  = in_xfer & has_data;
    assign fifo_pop = m_valid & m_ready;
    assign beat     = fifo_pop;
    assign m_data   = in_xfer ? fifo_data : 32'd0;
    assign m_slot   = in_xfer ? 8'(tail_q) : 8'd0;
    assign m_word   = in_xfer ? word_cnt : 4'd0;
    assign m_last   = in_xfer & (word_cnt == LAST_WORD);

    assign db_valid = in_db;
    assign db_value = in_db ? 8'(tail_q) : 8'd0;

    assign sq_tail      = 8'(tail_q);
    assign sq_head_q    = 8'(head_q);
    assign sq_full      = (tail_inc == head_q);
    assign underrun_err = underrun_q;

    // Only the low PW bits of the reported head are meaningful.
    assign unused_head_hi = ^sq_head;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state      <= IDLE;
            word_cnt   <= 4'd0;
            tail_q     <= '0;
            head_q     <= '0;
            underrun_q <= 1'b0;
        end else begin
            if (sq_head_valid)
                head_q <= sq_head[PW-1:0];
            case (state)
                IDLE: begin
                    if (enable && fifo_data_count >= 15'(CMD_WORDS) && !sq_full) begin
                        state    <= XFER;
                        word_cnt <= 4'd0;
                    end
                end
                XFER: begin
                    if (!has_data)
                        underrun_q <= 1'b1;
                    if (beat) begin
                        if (word_cnt == LAST_WORD) begin
                            tail_q   <= tail_inc;
                            word_cnt <= 4'd0;
                            state    <= DOORBELL;
                        end else begin
                            word_cnt <= word_cnt + 4'd1;
                        end
                    end
                end
                DOORBELL: begin
                    if (db_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sq_cmd_scheduler.sv
// Directed bench for sq_cmd_scheduler: basic transfer, backpressure, doorbell
// stall, underrun, mid-command reset and SQ full/wrap.
module tb_sq_cmd_scheduler;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b1;
    logic        enable = 1'b0;
    logic [14:0] fifo_data_count;
    logic [31:0] fifo_data;
    logic        fifo_pop;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic [31:0] m_data;
    logic [7:0]  m_slot;
    logic [3:0]  m_word;
    logic        m_last;
    logic        sq_head_valid = 1'b0;
    logic [7:0]  sq_head = 8'd0;
    logic        db_valid;
    logic        db_ready = 1'b1;
    logic [7:0]  db_value;
    logic [7:0]  sq_tail;
    logic [7:0]  sq_head_q;
    logic        sq_full;
    logic        underrun_err;

    int          ntests = 0;
    int          nfail = 0;
    int          pops = 0;
    int          pop_viol = 0;
    bit          hide = 1'b0;
    bit          pend_pop = 1'b0;
    logic [31:0] q[$];
    logic [44:0] log_beat[$];

    sq_cmd_scheduler #(.SQ_DEPTH(64), .CMD_WORDS(16)) dut (
        .aclk(aclk), .aresetn(aresetn), .enable(enable),
        .fifo_data_count(fifo_data_count), .fifo_data(fifo_data), .fifo_pop(fifo_pop),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_slot(m_slot),
        .m_word(m_word), .m_last(m_last), .sq_head_valid(sq_head_valid), .sq_head(sq_head),
        .db_valid(db_valid), .db_ready(db_ready), .db_value(db_value),
        .sq_tail(sq_tail), .sq_head_q(sq_head_q), .sq_full(sq_full), .underrun_err(underrun_err)
    );

    always #5 aclk = ~aclk;

    function automatic logic [31:0] mk(input int cmd, input int w);
        return 32'hD000_0000 | 32'(cmd << 8) | 32'(w);
    endfunction

    task automatic fifo_sync();
        fifo_data_count = hide ? 15'd0 : 15'(q.size());
        fifo_data       = (q.size() != 0) ? q[0] : 32'd0;
    endtask

    task automatic push_cmd(input int cmd);
        for (int w = 0; w < 16; w++) q.push_back(mk(cmd, w));
        fifo_sync();
    endtask

    task automatic wait_db(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge aclk);
            if (db_valid) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_beats(input int n);
        for (int c = 0; c < 300 && log_beat.size() < n; c++) begin
            @(posedge aclk); #2;
        end
    endtask

    // Beat monitor: a beat is accepted at the posedge following a negedge with valid&ready.
    always @(negedge aclk) begin
        if (fifo_pop !== (m_valid & m_ready)) pop_viol++;
        if (aresetn && m_valid && m_ready) begin
            log_beat.push_back({m_data, m_slot, m_word, m_last});
            pend_pop = 1'b1;
        end
    end

    always @(posedge aclk) begin
        #1;
        if (pend_pop) begin
            if (q.size() != 0) void'(q.pop_front());
            pops++;
            pend_pop = 1'b0;
        end
        fifo_sync();
    end

    task automatic test_reset();
        #2 aresetn = 1'b0;
        #1;
        ntests++; if ({fifo_pop, m_valid, db_valid, m_last} !== 4'b0) begin nfail++;
            $display("FAIL reset_hs: got %b want 0000", {fifo_pop, m_valid, db_valid, m_last}); end
        ntests++; if ({m_data, m_slot, m_word, db_value} !== 52'd0) begin nfail++;
            $display("FAIL reset_data: got %h want 0", {m_data, m_slot, m_word, db_value}); end
        ntests++; if ({sq_tail, sq_head_q, sq_full, underrun_err} !== 18'd0) begin nfail++;
            $display("FAIL reset_ptrs: got %h want 0", {sq_tail, sq_head_q, sq_full, underrun_err}); end
        @(posedge aclk); #2 aresetn = 1'b1;
        @(negedge aclk);
        ntests++; if ({m_valid, sq_tail} !== 9'd0) begin nfail++;
            $display("FAIL reset_release: got %h want 0", {m_valid, sq_tail}); end
    endtask

    task automatic test_basic();
        bit ok;
        logic [44:0] exp;
        log_beat.delete();
        push_cmd(0);
        repeat (3) @(negedge aclk);
        ntests++; if (m_valid !== 1'b0 || fifo_data_count !== 15'd16) begin nfail++;
            $display("FAIL basic_disabled: got valid=%b cnt=%0d want 0/16", m_valid, fifo_data_count); end
        @(posedge aclk); #1 enable = 1'b1;
        wait_db(ok);
        ntests++; if (!ok) begin nfail++; $display("FAIL basic_timeout: no doorbell"); end
        ntests++; if (log_beat.size() != 16) begin nfail++;
            $display("FAIL basic_beats: got %0d want 16", log_beat.size()); end
        for (int i = 0; i < 16 && i < log_beat.size(); i++) begin
            exp = {mk(0, i), 8'd0, 4'(i), (i == 15)};
            ntests++; if (log_beat[i] !== exp) begin nfail++;
                $display("FAIL basic_beat%0d: got %h want %h", i, log_beat[i], exp); end
        end
        ntests++; if (db_value !== 8'd1 || sq_tail !== 8'd1) begin nfail++;
            $display("FAIL basic_db: got db=%0d tail=%0d want 1/1", db_value, sq_tail); end
        @(posedge aclk); #1;
    endtask

    task automatic test_backpressure();
        bit ok;
        int bp_viol, p0;
        logic [31:0] hold;
        bit held;
        logic [44:0] exp;
        bp_viol = 0; held = 1'b0; hold = 32'd0; p0 = pops; ok = 1'b0;
        log_beat.delete();
        push_cmd(1);
        for (int c = 0; c < 300; c++) begin
            @(negedge aclk);
            if (db_valid) begin ok = 1'b1; break; end
            if (held && m_data !== hold) bp_viol++;
            if (fifo_pop && !m_ready) bp_viol++;
            held = m_valid && !m_ready;
            hold = m_data;
            @(posedge aclk); #1 m_ready = ~m_ready;
        end
        m_ready = 1'b1;
        ntests++; if (!ok) begin nfail++; $display("FAIL bp_timeout: no doorbell"); end
        ntests++; if (bp_viol != 0) begin nfail++; $display("FAIL bp_stable: got %0d violations want 0", bp_viol); end
        ntests++; if (pops - p0 != 16 || q.size() != 0) begin nfail++;
            $display("FAIL bp_pops: got %0d left %0d want 16/0", pops - p0, q.size()); end
        for (int i = 0; i < 16 && i < log_beat.size(); i++) begin
            exp = {mk(1, i), 8'd1, 4'(i), (i == 15)};
            ntests++; if (log_beat[i] !== exp) begin nfail++;
                $display("FAIL bp_beat%0d: got %h want %h", i, log_beat[i], exp); end
        end
        ntests++; if (db_value !== 8'd2 || sq_tail !== 8'd2) begin nfail++;
            $display("FAIL bp_db: got db=%0d tail=%0d want 2/2", db_value, sq_tail); end
        @(posedge aclk); #1;
    endtask

    task automatic test_doorbell_stall();
        bit ok;
        int st_viol, p0;
        logic [44:0] exp;
        st_viol = 0;
        log_beat.delete();
        db_ready = 1'b0;
        push_cmd(2); push_cmd(3);
        wait_db(ok);
        ntests++; if (!ok) begin nfail++; $display("FAIL stall_timeout: no doorbell"); end
        p0 = pops;
        repeat (10) begin
            @(posedge aclk); @(negedge aclk);
            if (fifo_pop !== 1'b0 || db_valid !== 1'b1 || db_value !== 8'd3 || fifo_data_count !== 15'd16)
                st_viol++;
        end
        ntests++; if (st_viol != 0 || pops != p0) begin nfail++;
            $display("FAIL stall_hold: got %0d violations %0d pops want 0/0", st_viol, pops - p0); end
        for (int i = 0; i < 16 && i < log_beat.size(); i++) begin
            exp = {mk(2, i), 8'd2, 4'(i), (i == 15)};
            ntests++; if (log_beat[i] !== exp) begin nfail++;
                $display("FAIL stall_beat%0d: got %h want %h", i, log_beat[i], exp); end
        end
        @(posedge aclk); #1 db_ready = 1'b1;
        log_beat.delete();
        @(posedge aclk); #1;
        wait_db(ok);
        ntests++; if (!ok || log_beat.size() != 16) begin nfail++;
            $display("FAIL stall_second: got ok=%0d beats=%0d want 1/16", ok, log_beat.size()); end
        ntests++; if (log_beat.size() > 0 && log_beat[0] !== {mk(3, 0), 8'd3, 4'd0, 1'b0}) begin nfail++;
            $display("FAIL stall_second_first: got %h want %h", log_beat[0], {mk(3, 0), 8'd3, 4'd0, 1'b0}); end
        ntests++; if (db_value !== 8'd4 || sq_tail !== 8'd4) begin nfail++;
            $display("FAIL stall_db: got db=%0d tail=%0d want 4/4", db_value, sq_tail); end
        @(posedge aclk); #1;
    endtask

    task automatic test_underrun();
        bit ok;
        logic [44:0] exp;
        log_beat.delete();
        push_cmd(4);
        wait_beats(7);
        hide = 1'b1; fifo_sync();
        repeat (3) @(negedge aclk);
        ntests++; if ({underrun_err, m_valid, fifo_pop, m_word} !== {1'b1, 1'b0, 1'b0, 4'd7}) begin nfail++;
            $display("FAIL underrun_hold: got err=%b v=%b pop=%b word=%0d want 1/0/0/7",
                     underrun_err, m_valid, fifo_pop, m_word); end
        @(posedge aclk); #2 hide = 1'b0; fifo_sync();
        wait_db(ok);
        ntests++; if (!ok || log_beat.size() != 16) begin nfail++;
            $display("FAIL underrun_resume: got ok=%0d beats=%0d want 1/16", ok, log_beat.size()); end
        for (int i = 0; i < 16 && i < log_beat.size(); i++) begin
            exp = {mk(4, i), 8'd4, 4'(i), (i == 15)};
            ntests++; if (log_beat[i] !== exp) begin nfail++;
                $display("FAIL underrun_beat%0d: got %h want %h", i, log_beat[i], exp); end
        end
        ntests++; if (db_value !== 8'd5 || underrun_err !== 1'b1) begin nfail++;
            $display("FAIL underrun_db: got db=%0d err=%b want 5/1", db_value, underrun_err); end
        @(posedge aclk); #1;
    endtask

    task automatic test_reset_mid();
        log_beat.delete();
        push_cmd(5);
        wait_beats(9);
        ntests++; if (m_word !== 4'd9) begin nfail++; $display("FAIL rstmid_word: got %0d want 9", m_word); end
        aresetn = 1'b0;
        #1;
        ntests++; if ({fifo_pop, m_valid, db_valid, m_last, m_data, m_slot, m_word} !== 48'd0) begin nfail++;
            $display("FAIL rstmid_outs: got %h want 0", {fifo_pop, m_valid, db_valid, m_last, m_data, m_slot, m_word}); end
        ntests++; if (sq_tail !== 8'd0 || underrun_err !== 1'b0) begin nfail++;
            $display("FAIL rstmid_state: got tail=%0d err=%b want 0/0", sq_tail, underrun_err); end
        q.delete(); log_beat.delete(); pend_pop = 1'b0; fifo_sync();
        #1 aresetn = 1'b1;
        @(negedge aclk);
        ntests++; if ({m_valid, db_valid, sq_tail} !== 10'd0) begin nfail++;
            $display("FAIL rstmid_idle: got %h want 0", {m_valid, db_valid, sq_tail}); end
        @(posedge aclk); #1;
    endtask

    task automatic test_full_wrap();
        bit ok;
        int done;
        logic [44:0] exp;
        done = 0;
        for (int c = 0; c < 64; c++) push_cmd(10 + c);
        for (int c = 0; c < 63; c++) begin
            wait_db(ok);
            if (!ok) break;
            done++;
            @(posedge aclk); #1;
        end
        ntests++; if (done != 63) begin nfail++; $display("FAIL full_cmds: got %0d want 63", done); end
        ntests++; if (sq_tail !== 8'd63 || sq_full !== 1'b1) begin nfail++;
            $display("FAIL full_flag: got tail=%0d full=%b want 63/1", sq_tail, sq_full); end
        repeat (5) @(negedge aclk);
        ntests++; if (m_valid !== 1'b0 || q.size() != 16) begin nfail++;
            $display("FAIL full_blocked: got valid=%b left=%0d want 0/16", m_valid, q.size()); end
        log_beat.delete();
        @(posedge aclk); #1 sq_head_valid = 1'b1; sq_head = 8'hC5;
        @(posedge aclk); #1 sq_head_valid = 1'b0; sq_head = 8'h00;
        wait_db(ok);
        ntests++; if (!ok || log_beat.size() != 16) begin nfail++;
            $display("FAIL wrap_beats: got ok=%0d beats=%0d want 1/16", ok, log_beat.size()); end
        for (int i = 0; i < 16 && i < log_beat.size(); i++) begin
            exp = {mk(73, i), 8'd63, 4'(i), (i == 15)};
            ntests++; if (log_beat[i] !== exp) begin nfail++;
                $display("FAIL wrap_beat%0d: got %h want %h", i, log_beat[i], exp); end
        end
        ntests++; if ({db_value, sq_tail, sq_head_q, sq_full} !== {8'd0, 8'd0, 8'd5, 1'b0}) begin nfail++;
            $display("FAIL wrap_ptrs: got db=%0d tail=%0d head=%0d full=%b want 0/0/5/0",
                     db_value, sq_tail, sq_head_q, sq_full); end
        @(posedge aclk); #1;
    endtask

    task automatic test_pop_rule();
        ntests++; if (pop_viol != 0) begin nfail++;
            $display("FAIL pop_rule: got %0d cycles with pop != valid&ready want 0", pop_viol); end
    endtask

    initial begin
        fifo_sync();
        test_reset();
        test_basic();
        test_backpressure();
        test_doorbell_stall();
        test_underrun();
        test_reset_mid();
        test_full_wrap();
        test_pop_rule();
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
